// File: rtl/gelato_types.sv
// Shared types for the gelato core: word/address widths and the byte-wide RAM port.
// Pure declarations; no logic, no latency, no flow control.
package gelato_types;

    localparam int DATA_WIDTH             = 32;
    localparam int RAM_ADDR_WIDTH_DEFAULT = 17;

    typedef logic [DATA_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [7:0]            byte_t;

endpackage

// File: rtl/gelato_ram_ctrl_if.sv
// LSU-to-RAM-controller word request bus: the requester holds req_valid until it sees resp_done.
// No latency of its own; flow control is the valid/done handshake.
interface gelato_ram_ctrl_if;
    import gelato_types::*;

    logic  req_valid;
    logic  req_write;
    addr_t req_addr;
    data_t req_wdata;
    logic  resp_done;
    data_t resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  resp_done, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output resp_done, resp_rdata
    );
endinterface

// File: rtl/gelato_ram_ctrl.sv
// Splits one 32-bit LSU load/store into four little-endian accesses on a byte-wide synchronous RAM.
// Latency: load done in the 9th enabled cycle after acceptance, store in the 5th.
// Backpressure: rdy=0 freezes all state and suppresses the write strobe; one request at a time.
module gelato_ram_ctrl
    import gelato_types::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    gelato_ram_ctrl_if.slave          lsu,
    output logic [RAM_ADDR_WIDTH-1:0] mem_a,
    output logic                      mem_wr,
    output byte_t                     mem_dout,
    input  byte_t                     mem_din
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        DONE
    } state_t;

    state_t                    state;
    logic [1:0]                idx;
    logic [RAM_ADDR_WIDTH-1:0] base;
    data_t                     wdata;
    logic [23:0]               shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 2'd0;
            base           <= '0;
            wdata          <= '0;
            shadow         <= '0;
            lsu.resp_done  <= 1'b0;
            lsu.resp_rdata <= '0;
        end else if (rdy) begin
            lsu.resp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        base  <= {lsu.req_addr[RAM_ADDR_WIDTH-1:2], 2'b00};
                        wdata <= lsu.req_wdata;
                        idx   <= 2'd0;
                        state <= lsu.req_write ? WR : RD_ADDR;
                    end
                end
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    // The top byte goes straight into the response word, so the shadow only holds three lanes.
                    case (idx)
                        2'd0:    shadow[7:0]   <= mem_din;
                        2'd1:    shadow[15:8]  <= mem_din;
                        2'd2:    shadow[23:16] <= mem_din;
                        default: shadow        <= shadow;
                    endcase
                    if (idx == 2'd3) begin
                        lsu.resp_rdata <= {mem_din, shadow};
                        lsu.resp_done  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= RD_ADDR;
                    end
                end
                WR: begin
                    if (idx == 2'd3) begin
                        lsu.resp_done <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data are decoded from frozen registers, so a stall holds them; only the strobe needs rdy.
    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if (state != IDLE) begin
            mem_a = base + RAM_ADDR_WIDTH'(idx);
        end
        if (state == WR) begin
            mem_dout = wdata[8*idx +: 8];
            mem_wr   = rdy;
        end
    end

endmodule

// File: tb/tb_gelato_ram_ctrl.sv
// Bench for gelato_ram_ctrl: directed latency/stall/wrap/reset cases plus randomized traffic
// checked against a flat byte-array memory model.
module tb_gelato_ram_ctrl;
    localparam int RAW       = 17;
    localparam int RAM_BYTES = 1 << RAW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rdy;
    logic [RAW-1:0] mem_a;
    logic           mem_wr;
    logic [7:0]     mem_dout;
    logic [7:0]     mem_din;

    int checks = 0;
    int errors = 0;

    gelato_ram_ctrl_if bus ();

    gelato_ram_ctrl #(.RAM_ADDR_WIDTH(RAW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .lsu      (bus.slave),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency plus a backdoor for preloading.
    logic [7:0]     ram [RAM_BYTES];
    logic [7:0]     ref_mem [RAM_BYTES];
    logic           bd_fill = 1'b0;
    logic           bd_we   = 1'b0;
    logic [RAW-1:0] bd_addr = '0;
    logic [7:0]     bd_data = '0;
    int             wr_cnt  = 0;
    logic [RAW-1:0] log_a [$];
    logic [7:0]     log_d [$];

    function automatic logic [7:0] pat(int i);
        return 8'((i * 7) ^ (i >> 8) ^ 8'h5A);
    endfunction

    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= pat(i);
        end else begin
            if (bd_we) ram[bd_addr] <= bd_data;
            if (mem_wr) begin
                ram[mem_a] <= mem_dout;
                log_a.push_back(mem_a);
                log_d.push_back(mem_dout);
                wr_cnt++;
            end
        end
        mem_din <= ram[mem_a];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bd_write(input logic [RAW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic logic [RAW-1:0] wbase(logic [31:0] a);
        return {a[RAW-1:2], 2'b00};
    endfunction

    // Starts and ends at a negedge with the controller in IDLE.
    task automatic run_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int stall_pct, input int stall_at, input int stall_len,
                           output logic [31:0] rd, output int lat, output int wall, output int nwr);
        int k, w, w0, stalled;
        bit seen;
        k = 0; w = 0; stalled = 0; seen = 1'b0; rd = 'x;
        w0 = wr_cnt;
        log_a.delete(); log_d.delete();
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wd;
        rdy = ($urandom_range(99) >= stall_pct);
        for (int c = 0; c < 300 && !seen; c++) begin
            @(posedge clk); #1;
            if (rdy) k++;
            if (k > 0) w++;
            if (bus.resp_done) begin
                seen = 1'b1;
                rd   = bus.resp_rdata;
            end else begin
                @(negedge clk);
                if (stall_len > 0 && k == stall_at && stalled < stall_len) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(99) >= stall_pct);
                end
                #1;
                if (!rdy) chk("no_strobe_while_stalled", mem_wr, 0);
            end
        end
        chk("done_seen", seen, 1);
        lat  = seen ? k : -1;
        wall = w;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("done_single_cycle", bus.resp_done, 0);
        @(negedge clk);
        nwr = wr_cnt - w0;
    endtask

    task automatic check_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                             input int stall_pct, input int stall_at, input int stall_len,
                             input int exp_wall, output logic [31:0] rd);
        int lat, wall, nwr;
        logic [RAW-1:0] b;
        logic [31:0]    exp_word;
        b = wbase(addr);
        for (int i = 0; i < 4; i++) exp_word[8*i +: 8] = ref_mem[RAW'(b + RAW'(i))];
        run_req(wr, addr, wd, stall_pct, stall_at, stall_len, rd, lat, wall, nwr);
        if (wr) begin
            chk("store_latency", lat, 5);
            chk("store_strobes", nwr, 4);
            if (log_a.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    chk("store_addr", log_a[i], RAW'(b + RAW'(i)));
                    chk("store_byte", log_d[i], wd[8*i +: 8]);
                end
            end
            for (int i = 0; i < 4; i++) ref_mem[RAW'(b + RAW'(i))] = wd[8*i +: 8];
        end else begin
            chk("load_data", rd, exp_word);
            chk("load_latency", lat, 9);
            chk("load_strobes", nwr, 0);
        end
        if (exp_wall >= 0) chk("wall_cycles", wall, exp_wall);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a, d;
        bit          w;

        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = pat(i);
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rdy = 1'b1;
        rst_n = 1'b0;
        bd_fill = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bd_fill = 1'b0;
        #1;
        chk("rst_done", bus.resp_done, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        bd_write(17'h100, 8'h11);
        bd_write(17'h101, 8'h22);
        bd_write(17'h102, 8'h33);
        bd_write(17'h103, 8'h44);
        @(negedge clk);
        check_txn(1'b0, 32'h0000_0100, '0, 0, 0, 0, 9, rd);
        chk("load_0x100_word", rd, 32'h4433_2211);

        check_txn(1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 0, 0, 0, 5, rd);
        // Three stalled cycles in the middle of the second byte write.
        check_txn(1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 0, 2, 3, 8, rd);
        check_txn(1'b0, 32'h0000_0204, '0, 0, 0, 0, 9, rd);
        chk("readback_0x204", rd, 32'hDEAD_BEEF);

        check_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, 0, 5, rd);
        check_txn(1'b0, 32'h0000_0010, '0, 0, 0, 0, 9, rd);
        chk("back_to_back_word", rd, 32'hCAFE_F00D);

        check_txn(1'b0, 32'h0000_0103, '0, 0, 0, 0, 9, rd);
        chk("misaligned_word", rd, 32'h4433_2211);
        check_txn(1'b0, 32'hFFFE_0101, '0, 0, 0, 0, 9, rd);
        chk("high_bits_ignored", rd, 32'h4433_2211);
        check_txn(1'b1, 32'h0001_FFFC, 32'h0BAD_F00D, 0, 0, 0, 5, rd);
        check_txn(1'b0, 32'h0001_FFFE, '0, 0, 0, 0, 9, rd);
        chk("top_of_ram_word", rd, 32'h0BAD_F00D);

        // Reset while reading the third byte: nothing completes, outputs return to reset values.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0100;
        rdy = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("midrst_done", bus.resp_done, 0);
        chk("midrst_rdata", bus.resp_rdata, 0);
        chk("midrst_mem_a", mem_a, 0);
        chk("midrst_mem_wr", mem_wr, 0);
        chk("midrst_mem_dout", mem_dout, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_done", bus.resp_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_txn(1'b0, 32'h0000_0100, '0, 0, 0, 0, 9, rd);
        chk("after_reset_word", rd, 32'h4433_2211);

        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(1));
            a = $urandom;
            if ($urandom_range(4) == 0) a = {a[31:RAW], 15'h7FFF, a[1:0]};
            else if ($urandom_range(3) == 0) a = {a[31:12], 10'h040, a[1:0]};
            d = $urandom;
            check_txn(w, a, d, 30, 0, 0, -1, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
